seq_mul: RTL and testbench

- Iterative shift-add multiplier, the companion of the team's restoring divider in the CPU execute datapath.
- Computes a WIDTH x WIDTH product, 2*WIDTH bits wide, returned as hi/lo halves for the HI/LO register pair.
- Retires one multiplier bit per clock.
- Uses the same start/ready style handshake as the divider, so the control unit drives both units the same way.

---
 rtl/seq_mul.sv | 103 ++++++++++
 tb/tb_seq_mul.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_mul.sv
// seq_mul: iterative shift-add multiplier with start/ready handshake.
// Operands are converted to magnitudes on capture, multiplied one bit per
// clock, and the sign is re-applied to the full 2*WIDTH product in FINISH.
module seq_mul #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo
);

  typedef enum logic [1:0] {IDLE, BUSY, FINISH} state_t;

  localparam logic [WIDTH-1:0]   ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W  = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_INI = CNT_W'(WIDTH);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   mcand, mplier;
  logic [WIDTH:0]     acc, sum;
  logic [CNT_W-1:0]   cnt;
  logic               neg;
  logic               a_neg, b_neg;
  logic [2*WIDTH-1:0] prod_raw, prod_fix;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake decode.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = BUSY;
      end
      BUSY:    if (cnt == CNT_ONE) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand sign detection, partial-sum adder and final sign fix-up.
  always_comb begin
    a_neg    = is_signed & multiplicand[WIDTH-1];
    b_neg    = is_signed & multiplier[WIDTH-1];
    sum      = mplier[0] ? (acc + {1'b0, mcand}) : acc;
    prod_raw = {acc[WIDTH-1:0], mplier};
    prod_fix = neg ? (~prod_raw + ONE_2W) : prod_raw;
  end

  // Datapath: capture, shift-add iterations, result registration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      cnt        <= '0;
      neg        <= 1'b0;
      done       <= 1'b0;
      product_hi <= '0;
      product_lo <= '0;
    end else begin
      done <= (state == FINISH);
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= a_neg ? (~multiplicand + ONE_W) : multiplicand;
            mplier <= b_neg ? (~multiplier + ONE_W) : multiplier;
            neg    <= a_neg ^ b_neg;
            acc    <= '0;
            cnt    <= CNT_INI;
          end
        end
        BUSY: begin
          // {acc, mplier} <= {sum, mplier} >> 1, split across the two registers
          acc    <= {1'b0, sum[WIDTH:1]};
          mplier <= {sum[0], mplier[WIDTH-1:1]};
          cnt    <= cnt - CNT_ONE;
        end
        FINISH: begin
          product_hi <= prod_fix[2*WIDTH-1:WIDTH];
          product_lo <= prod_fix[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mul.sv
// tb_seq_mul: directed and randomized checks of seq_mul against a plain
// 64-bit arithmetic reference product.
module tb_seq_mul;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] multiplicand = '0;
  logic [31:0] multiplier = '0;
  logic        ready, done;
  logic [31:0] product_hi, product_lo;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cyc = 0;

  seq_mul #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .ready(ready), .done(done),
    .product_hi(product_hi), .product_lo(product_lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    longint sa, sb;
    longint unsigned ua, ub;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'b0, a};
    ub = {32'b0, b};
    return ua * ub;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Waits for ready, drives one start pulse, then scrambles inputs.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    int n = 0;
    while (!ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("ready_before_start", {63'b0, ready}, 64'd1);
    multiplicand = a;
    multiplier   = b;
    is_signed    = s;
    start        = 1'b1;
    @(posedge clk); #1;
    start_cyc    = cyc;
    start        = 1'b0;
    multiplicand = $urandom;
    multiplier   = $urandom;
    is_signed    = 1'($urandom);
  endtask

  task automatic wait_done(output int lat);
    while (!done && (cyc - start_cyc) < 80) begin
      @(posedge clk); #1;
    end
    lat = cyc - start_cyc;
    done_cyc = cyc;
    check("done_seen", {63'b0, done}, 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s);
    int lat;
    start_op(a, b, s);
    wait_done(lat);
    check({tag, "_lat"}, 64'(lat), 64'd33);
    check({tag, "_prod"}, {product_hi, product_lo}, ref_mul(a, b, s));
    check({tag, "_ready"}, {63'b0, ready}, 64'd1);
    @(posedge clk); #1;
    check({tag, "_done_1cyc"}, {63'b0, done}, 64'd0);
  endtask

  initial begin : main
    int lat, d1, n_done;
    logic [31:0] a, b;
    logic s;
    logic [63:0] held;

    // Reset state before any clock edge
    #2;
    check("rst_ready", {63'b0, ready}, 64'd1);
    check("rst_done", {63'b0, done}, 64'd0);
    check("rst_prod", {product_hi, product_lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed spec values
    run_op("warm", 32'd7, 32'd9, 1'b0);
    check("warm_val", {product_hi, product_lo}, 64'd63);

    // Asynchronous abort mid-BUSY
    start_op(32'd1234, 32'd5678, 1'b0);
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_ready", {63'b0, ready}, 64'd1);
    check("abort_done", {63'b0, done}, 64'd0);
    check("abort_prod", {product_hi, product_lo}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    n_done = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    check("abort_no_done", 64'(n_done), 64'd0);

    run_op("u3x5", 32'd3, 32'd5, 1'b0);
    check("u3x5_val", {product_hi, product_lo}, 64'h0000_0000_0000_000F);
    run_op("umax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("umax_val", {product_hi, product_lo}, 64'hFFFF_FFFE_0000_0001);
    run_op("sm7x6", -32'sd7, 32'd6, 1'b1);
    check("sm7x6_val", {product_hi, product_lo}, 64'hFFFF_FFFF_FFFF_FFD6);
    run_op("sm7xm6", -32'sd7, -32'sd6, 1'b1);
    check("sm7xm6_val", {product_hi, product_lo}, 64'h0000_0000_0000_002A);
    run_op("smin2", 32'h8000_0000, 32'h8000_0000, 1'b1);
    check("smin2_val", {product_hi, product_lo}, 64'h4000_0000_0000_0000);
    run_op("u8x2", 32'h8000_0000, 32'd2, 1'b0);
    check("u8x2_val", {product_hi, product_lo}, 64'h0000_0001_0000_0000);
    run_op("s8x2", 32'h8000_0000, 32'd2, 1'b1);
    check("s8x2_val", {product_hi, product_lo}, 64'hFFFF_FFFF_0000_0000);
    run_op("zero", 32'd0, 32'h1234_5678, 1'b1);
    check("zero_val", {product_hi, product_lo}, 64'd0);
    run_op("szero", -32'sd5, 32'd0, 1'b1);
    check("szero_val", {product_hi, product_lo}, 64'd0);

    // Start during BUSY is ignored
    start_op(32'd100, 32'd200, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    multiplicand = 32'd9; multiplier = 32'd9; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat);
    check("ign_lat", 64'(lat), 64'd33);
    check("ign_prod", {product_hi, product_lo}, 64'd20000);
    n_done = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    check("ign_no_second_done", 64'(n_done), 64'd0);
    check("hold_idle", {product_hi, product_lo}, 64'd20000);

    // Hold through the next op's BUSY phase
    start_op(32'd3, 32'd3, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    check("hold_busy", {product_hi, product_lo}, 64'd20000);
    check("busy_not_ready", {63'b0, ready}, 64'd0);
    wait_done(lat);
    check("hold_new", {product_hi, product_lo}, 64'd9);

    // Back-to-back: next start in the first ready cycle
    start_op(32'd11, 32'd13, 1'b0);
    check("b2b_start_cyc", 64'(start_cyc - done_cyc), 64'd1);
    wait_done(lat);
    d1 = done_cyc;
    check("b2b_a", {product_hi, product_lo}, 64'd143);
    start_op(-32'sd17, 32'd19, 1'b1);
    wait_done(lat);
    check("b2b_spacing", 64'(done_cyc - d1), 64'd34);
    check("b2b_b", {product_hi, product_lo}, ref_mul(-32'sd17, 32'd19, 1'b1));

    // Randomized operands, with occasional boundary values
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      b = $urandom;
      s = 1'($urandom);
      case ($urandom_range(0, 9))
        0: a = 32'h8000_0000;
        1: b = 32'hFFFF_FFFF;
        2: a = '0;
        3: b = 32'h7FFF_FFFF;
        default: ;
      endcase
      start_op(a, b, s);
      wait_done(lat);
      check("rnd_lat", 64'(lat), 64'd33);
      check("rnd_prod", {product_hi, product_lo}, ref_mul(a, b, s));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
